// File: rtl/interrupt_request_resolver_pkg.sv
// Package for interrupt_request_resolver.
// Holds the FSM state encoding, the fixed level count, the default spurious
// level and small one-hot/binary/priority helpers shared by the resolver.
package interrupt_request_resolver_pkg;

    localparam int         IRQ_LEVELS          = 8;
    localparam logic [2:0] IRQ_SPURIOUS_LEVEL  = 3'd7;

    // INTA sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK1  = 2'd1,
        ST_WAIT2 = 2'd2,
        ST_ACK2  = 2'd3
    } resolver_state_t;

    function automatic logic [7:0] bin_to_onehot(input logic [2:0] level);
        return 8'b0000_0001 << level;
    endfunction

    function automatic logic [2:0] onehot_to_bin(input logic [7:0] onehot);
        logic [2:0] level;
        level = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                level = level | 3'(i);
            end
        end
        return level;
    endfunction

    // Rank 0 is the highest priority: the level just above the lowest pointer.
    function automatic logic [2:0] priority_rank(input logic [2:0] level,
                                                 input logic [2:0] lowest);
        return level - lowest - 3'd1;
    endfunction

endpackage

// File: rtl/interrupt_request_resolver_if.sv
// Bus interface for interrupt_request_resolver.
// Groups the IR pins, configuration (mode, mask, rotation), the CPU INTA
// handshake and the ISR-facing outputs. fsm_state exposes the sequencer
// state for observation.
//
// Handshake: the CPU acknowledges with two active-low INTA pulses. A falling
// edge of interrupt_acknowledge_n (previous sample high, current low) is the
// only event the resolver reacts to; the first one freezes the winner and
// produces acknowledge for one cycle, the second produces end_of_acknowledge
// for one cycle. There is no back-pressure and no timeout between them.
//
// Modports:
//   slave  - the resolver (consumes requests/config, drives results)
//   master - the environment (CPU / ISR block / configuration)
interface interrupt_request_resolver_if;
    import interrupt_request_resolver_pkg::*;

    logic [7:0]      interrupt_request_pin;
    logic            level_or_edge_triggered_config;
    logic [7:0]      interrupt_mask;
    logic            special_mask_mode;
    logic            interrupt_acknowledge_n;
    logic [7:0]      in_service_register;
    logic            priority_rotate;
    logic [2:0]      priority_rotate_level;

    logic            interrupt_to_cpu;
    logic [7:0]      highest_priority_interrupt;
    logic            acknowledge;
    logic            end_of_acknowledge;
    logic [2:0]      vector_level;
    logic [7:0]      interrupt_request_register;
    resolver_state_t fsm_state;

    modport slave (
        input  interrupt_request_pin, level_or_edge_triggered_config,
               interrupt_mask, special_mask_mode, interrupt_acknowledge_n,
               in_service_register, priority_rotate, priority_rotate_level,
        output interrupt_to_cpu, highest_priority_interrupt, acknowledge,
               end_of_acknowledge, vector_level, interrupt_request_register,
               fsm_state
    );

    modport master (
        output interrupt_request_pin, level_or_edge_triggered_config,
               interrupt_mask, special_mask_mode, interrupt_acknowledge_n,
               in_service_register, priority_rotate, priority_rotate_level,
        input  interrupt_to_cpu, highest_priority_interrupt, acknowledge,
               end_of_acknowledge, vector_level, interrupt_request_register,
               fsm_state
    );

endinterface

// File: rtl/interrupt_request_resolver_priority_rotation_encoder.sv
// priority_rotation_encoder: combinational rotating priority picker.
// Ports:
//   request      in  8  candidate bits
//   lowest_level in  3  lowest-priority level; search starts at lowest_level+1
//   winner       out 8  one-hot highest-priority set bit of request (0 if none)
//   valid        out 1  request has at least one set bit
module priority_rotation_encoder
    import interrupt_request_resolver_pkg::*;
(
    input  logic [7:0] request,
    input  logic [2:0] lowest_level,
    output logic [7:0] winner,
    output logic       valid
);

    logic [2:0] cand;
    logic [2:0] found_level;

    always_comb begin
        cand        = 3'd0;
        found_level = 3'd0;
        valid       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            // Walk levels in falling priority; the 3-bit add wraps mod 8.
            cand = lowest_level + 3'd1 + 3'(i);
            if (!valid && request[cand]) begin
                valid       = 1'b1;
                found_level = cand;
            end
        end
    end

    assign winner = valid ? bin_to_onehot(found_level) : 8'h00;

endmodule

// File: rtl/interrupt_request_resolver.sv
// interrupt_request_resolver: IRR + rotating priority resolver + INTA sequencer.
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  asynchronous, active-high
//   bus    interrupt_request_resolver_if.slave:
//     inputs  IR pins, LTIM mode, mask, special mask mode, INTA#, ISR,
//             rotation strobe + new lowest level
//     outputs INT, frozen one-hot winner, acknowledge, end_of_acknowledge,
//             vector_level, IRR read-back, fsm_state
module interrupt_request_resolver
    import interrupt_request_resolver_pkg::*;
#(
    parameter int         NUM_LEVELS     = IRQ_LEVELS,
    parameter logic [2:0] SPURIOUS_LEVEL = IRQ_SPURIOUS_LEVEL
) (
    input  logic                          clock,
    input  logic                          reset,
    interrupt_request_resolver_if.slave   bus
);

    logic [NUM_LEVELS-1:0] pin_q;
    logic [NUM_LEVELS-1:0] irr;
    logic [NUM_LEVELS-1:0] irr_next;
    logic [NUM_LEVELS-1:0] irr_set;
    logic [NUM_LEVELS-1:0] irr_clear;
    logic                  inta_q;
    logic                  inta_fall;
    logic [2:0]            lowest;

    resolver_state_t state, state_next;

    logic [7:0] pending;
    logic [7:0] arb_request;
    logic [7:0] req_winner;
    logic       req_valid;
    logic [7:0] isr_winner;
    logic       isr_valid;
    logic [2:0] req_level;
    logic [2:0] isr_level;
    logic       grant;

    logic       int_q;
    logic [7:0] highest_q;
    logic [2:0] vector_q;
    logic       ack_out;
    logic       eoa_out;

    // ---------------- arbitration ----------------
    assign pending = irr & ~bus.interrupt_mask;
    // In special mask mode an in-service level only blocks itself.
    assign arb_request = bus.special_mask_mode ? (pending & ~bus.in_service_register)
                                               : pending;

    priority_rotation_encoder u_req_encoder (
        .request      (arb_request),
        .lowest_level (lowest),
        .winner       (req_winner),
        .valid        (req_valid)
    );

    priority_rotation_encoder u_isr_encoder (
        .request      (bus.in_service_register),
        .lowest_level (lowest),
        .winner       (isr_winner),
        .valid        (isr_valid)
    );

    assign req_level = onehot_to_bin(req_winner);
    assign isr_level = onehot_to_bin(isr_winner);

    // Normal mode: the request must strictly outrank everything in service.
    assign grant = req_valid &&
                   (bus.special_mask_mode || !isr_valid ||
                    (priority_rank(req_level, lowest) < priority_rank(isr_level, lowest)));

    assign inta_fall = inta_q & ~bus.interrupt_acknowledge_n;

    // ---------------- IRR ----------------
    always_comb begin
        irr_set   = bus.interrupt_request_pin & ~pin_q;
        // Withdrawn pin or the level being acknowledged; clear beats set.
        irr_clear = ~bus.interrupt_request_pin |
                    ((state == ST_ACK1) ? highest_q : 8'h00);
        if (bus.level_or_edge_triggered_config) begin
            irr_next = bus.interrupt_request_pin;
        end else begin
            irr_next = (irr | irr_set) & ~irr_clear;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pin_q  <= '0;
            irr    <= '0;
            inta_q <= 1'b1;
            lowest <= 3'd7;
        end else begin
            pin_q  <= bus.interrupt_request_pin;
            irr    <= irr_next;
            inta_q <= bus.interrupt_acknowledge_n;
            if (bus.priority_rotate) begin
                lowest <= bus.priority_rotate_level;
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (inta_fall) state_next = ST_ACK1;
            ST_ACK1:  state_next = ST_WAIT2;
            ST_WAIT2: if (inta_fall) state_next = ST_ACK2;
            ST_ACK2:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ack_out = (state == ST_ACK1) && (highest_q != 8'h00);
        eoa_out = (state == ST_ACK2);
    end

    // ---------------- frozen winner and INT ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            int_q     <= 1'b0;
            highest_q <= 8'h00;
            vector_q  <= 3'd0;
        end else begin
            // INT follows the grant only while idle and not being acknowledged.
            int_q <= (state == ST_IDLE) && !inta_fall && grant;
            if ((state == ST_IDLE) && inta_fall) begin
                highest_q <= grant ? req_winner : 8'h00;
                vector_q  <= grant ? req_level  : SPURIOUS_LEVEL;
            end else if (state == ST_ACK2) begin
                highest_q <= 8'h00;
            end
        end
    end

    assign bus.interrupt_to_cpu           = int_q;
    assign bus.highest_priority_interrupt = highest_q;
    assign bus.acknowledge                = ack_out;
    assign bus.end_of_acknowledge         = eoa_out;
    assign bus.vector_level               = vector_q;
    assign bus.interrupt_request_register = irr;
    assign bus.fsm_state                  = state;

endmodule

// File: tb/tb_interrupt_request_resolver.sv
// Self-checking bench for interrupt_request_resolver.
module tb_interrupt_request_resolver;
    import interrupt_request_resolver_pkg::*;

    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    int   model_ptr;

    interrupt_request_resolver_if bus ();

    interrupt_request_resolver dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Returns the granted level or -1 when nothing would be granted.
    function automatic int model_winner(input logic [7:0] pend, input logic [7:0] isr,
                                        input int ptr, input logic smm);
        int kp;
        int ki;
        int lvl;
        kp = -1;
        ki = -1;
        for (int k = 0; k < 8; k++) begin
            lvl = (ptr + 1 + k) % 8;
            if (kp < 0 && pend[lvl] && !(smm && isr[lvl])) kp = k;
            if (ki < 0 && isr[lvl]) ki = k;
        end
        if (kp < 0) return -1;
        if (!smm && ki >= 0 && ki <= kp) return -1;
        return (ptr + 1 + kp) % 8;
    endfunction

    function automatic logic [7:0] lvl_onehot(input int lvl);
        logic [7:0] v;
        v = 8'h00;
        if (lvl >= 0) v[lvl] = 1'b1;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        bus.interrupt_request_pin = 8'h00;
        bus.in_service_register   = 8'h00;
        bus.interrupt_mask        = 8'h00;
        bus.special_mask_mode     = 1'b0;
        bus.interrupt_acknowledge_n = 1'b1;
        tick();
        tick();
    endtask

    // Ends just after the clock edge that sees the INTA falling edge.
    task automatic inta_pulse();
        bus.interrupt_acknowledge_n = 1'b0;
        tick();
        bus.interrupt_acknowledge_n = 1'b1;
    endtask

    task automatic rotate_to(input int lvl);
        bus.priority_rotate       = 1'b1;
        bus.priority_rotate_level = 3'(lvl);
        tick();
        bus.priority_rotate = 1'b0;
        model_ptr = lvl;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.interrupt_request_pin = 8'h00;
        bus.level_or_edge_triggered_config = 1'b0;
        bus.interrupt_mask = 8'h00;
        bus.special_mask_mode = 1'b0;
        bus.interrupt_acknowledge_n = 1'b1;
        bus.in_service_register = 8'h00;
        bus.priority_rotate = 1'b0;
        bus.priority_rotate_level = 3'd0;
        model_ptr = 7;
        tick();
        tick();
        total_cnt++;
        if ({bus.interrupt_to_cpu, bus.highest_priority_interrupt, bus.acknowledge,
             bus.end_of_acknowledge, bus.vector_level, bus.interrupt_request_register} !== 22'd0)
            $display("FAIL reset_outputs got=%b exp=0", {bus.interrupt_to_cpu,
                     bus.highest_priority_interrupt, bus.acknowledge, bus.end_of_acknowledge,
                     bus.vector_level, bus.interrupt_request_register});
        else pass_cnt++;
        total_cnt++;
        if (bus.fsm_state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=0", bus.fsm_state);
        else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_edge_basic();
        quiet();
        bus.interrupt_request_pin = 8'h08;
        tick();
        total_cnt++;
        if (bus.interrupt_to_cpu !== 1'b0) $display("FAIL t1_int_early got=%b exp=0", bus.interrupt_to_cpu);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.interrupt_to_cpu !== 1'b1) $display("FAIL t1_int got=%b exp=1", bus.interrupt_to_cpu);
        else pass_cnt++;
        inta_pulse();
        total_cnt++;
        if (bus.highest_priority_interrupt !== 8'h08 || bus.acknowledge !== 1'b1 ||
            bus.vector_level !== 3'd3 || bus.interrupt_to_cpu !== 1'b0)
            $display("FAIL t1_ack1 got=%h/%b/%0d/%b exp=08/1/3/0", bus.highest_priority_interrupt,
                     bus.acknowledge, bus.vector_level, bus.interrupt_to_cpu);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.acknowledge !== 1'b0 || bus.interrupt_request_register !== 8'h00)
            $display("FAIL t1_wait2 got=%b/%h exp=0/00", bus.acknowledge, bus.interrupt_request_register);
        else pass_cnt++;
        bus.interrupt_request_pin = 8'h00;
        inta_pulse();
        total_cnt++;
        if (bus.end_of_acknowledge !== 1'b1 || bus.interrupt_to_cpu !== 1'b0 ||
            bus.highest_priority_interrupt !== 8'h08)
            $display("FAIL t1_ack2 got=%b/%b/%h exp=1/0/08", bus.end_of_acknowledge,
                     bus.interrupt_to_cpu, bus.highest_priority_interrupt);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.end_of_acknowledge !== 1'b0 || bus.highest_priority_interrupt !== 8'h00)
            $display("FAIL t1_idle got=%b/%h exp=0/00", bus.end_of_acknowledge, bus.highest_priority_interrupt);
        else pass_cnt++;
    endtask

    task automatic test_rotation();
        quiet();
        bus.interrupt_request_pin = 8'h22;
        tick();
        tick();
        inta_pulse();
        total_cnt++;
        if (bus.highest_priority_interrupt !== 8'h02 || bus.vector_level !== 3'd1)
            $display("FAIL t2_ptr7 got=%h/%0d exp=02/1", bus.highest_priority_interrupt, bus.vector_level);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.interrupt_request_register !== 8'h20)
            $display("FAIL t2_irr got=%h exp=20", bus.interrupt_request_register);
        else pass_cnt++;
        inta_pulse();
        tick();
        rotate_to(1);
        quiet();
        bus.interrupt_request_pin = 8'h22;
        tick();
        tick();
        inta_pulse();
        total_cnt++;
        if (bus.highest_priority_interrupt !== 8'h20 || bus.vector_level !== 3'd5)
            $display("FAIL t2_ptr1 got=%h/%0d exp=20/5", bus.highest_priority_interrupt, bus.vector_level);
        else pass_cnt++;
        tick();
        inta_pulse();
        tick();
        rotate_to(7);
    endtask

    task automatic test_isr_blocking();
        logic [7:0] pins [4];
        logic       smm  [4];
        logic       exp  [4];
        pins = '{8'h10, 8'h01, 8'h10, 8'h04};
        smm  = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp  = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            quiet();
            bus.in_service_register   = 8'h04;
            bus.special_mask_mode     = smm[i];
            bus.interrupt_request_pin = pins[i];
            tick();
            tick();
            total_cnt++;
            if (bus.interrupt_to_cpu !== exp[i])
                $display("FAIL t3_isr_case%0d got=%b exp=%b", i, bus.interrupt_to_cpu, exp[i]);
            else pass_cnt++;
        end
        quiet();
    endtask

    task automatic test_spurious();
        quiet();
        bus.interrupt_request_pin = 8'h40;
        tick();
        tick();
        total_cnt++;
        if (bus.interrupt_to_cpu !== 1'b1) $display("FAIL t4_int got=%b exp=1", bus.interrupt_to_cpu);
        else pass_cnt++;
        bus.interrupt_request_pin = 8'h00;
        tick();
        inta_pulse();
        total_cnt++;
        if (bus.highest_priority_interrupt !== 8'h00 || bus.vector_level !== 3'd7 || bus.acknowledge !== 1'b0)
            $display("FAIL t4_spurious got=%h/%0d/%b exp=00/7/0", bus.highest_priority_interrupt,
                     bus.vector_level, bus.acknowledge);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.acknowledge !== 1'b0) $display("FAIL t4_noack got=%b exp=0", bus.acknowledge);
        else pass_cnt++;
        inta_pulse();
        total_cnt++;
        if (bus.end_of_acknowledge !== 1'b1) $display("FAIL t4_eoa got=%b exp=1", bus.end_of_acknowledge);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_level_mode();
        quiet();
        bus.level_or_edge_triggered_config = 1'b1;
        bus.interrupt_request_pin = 8'h04;
        tick();
        tick();
        total_cnt++;
        if (bus.interrupt_to_cpu !== 1'b1 || bus.interrupt_request_register !== 8'h04)
            $display("FAIL t5_int got=%b/%h exp=1/04", bus.interrupt_to_cpu, bus.interrupt_request_register);
        else pass_cnt++;
        inta_pulse();
        total_cnt++;
        if (bus.highest_priority_interrupt !== 8'h04 || bus.acknowledge !== 1'b1)
            $display("FAIL t5_ack1 got=%h/%b exp=04/1", bus.highest_priority_interrupt, bus.acknowledge);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.interrupt_request_register !== 8'h04)
            $display("FAIL t5_irr_held got=%h exp=04", bus.interrupt_request_register);
        else pass_cnt++;
        inta_pulse();
        tick();
        tick();
        total_cnt++;
        if (bus.interrupt_to_cpu !== 1'b1) $display("FAIL t5_int_again got=%b exp=1", bus.interrupt_to_cpu);
        else pass_cnt++;
        quiet();
        bus.level_or_edge_triggered_config = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_cycle();
        quiet();
        bus.interrupt_request_pin = 8'h08;
        tick();
        tick();
        inta_pulse();
        tick();
        total_cnt++;
        if (bus.fsm_state !== ST_WAIT2) $display("FAIL t6_in_wait2 got=%0d exp=2", bus.fsm_state);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({bus.interrupt_to_cpu, bus.highest_priority_interrupt, bus.acknowledge,
             bus.end_of_acknowledge, bus.vector_level} !== 14'd0 || bus.fsm_state !== ST_IDLE)
            $display("FAIL t6_async_reset got=%b/%0d exp=0/0", {bus.interrupt_to_cpu,
                     bus.highest_priority_interrupt, bus.acknowledge, bus.end_of_acknowledge,
                     bus.vector_level}, bus.fsm_state);
        else pass_cnt++;
        model_ptr = 7;
        tick();
        reset = 1'b0;
        bus.interrupt_request_pin = 8'h00;
        tick();
        inta_pulse();
        total_cnt++;
        if (bus.end_of_acknowledge !== 1'b0 || bus.fsm_state !== ST_ACK1 || bus.vector_level !== 3'd7)
            $display("FAIL t6_after_reset got=%b/%0d/%0d exp=0/1/7", bus.end_of_acknowledge,
                     bus.fsm_state, bus.vector_level);
        else pass_cnt++;
        tick();
        inta_pulse();
        tick();
    endtask

    task automatic test_random();
        logic [7:0] pins;
        logic [7:0] mask;
        logic [7:0] isr;
        logic       smm;
        logic       lvl_mode;
        int         w;
        logic [7:0] exp_oh;
        for (int it = 0; it < 40; it++) begin
            lvl_mode = 1'($urandom_range(0, 1));
            bus.level_or_edge_triggered_config = lvl_mode;
            quiet();
            if ($urandom_range(0, 2) == 0) rotate_to($urandom_range(0, 7));
            pins = 8'($urandom_range(0, 255));
            mask = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            isr  = ($urandom_range(0, 1) == 1) ? lvl_onehot($urandom_range(0, 7)) : 8'h00;
            smm  = 1'($urandom_range(0, 1));
            bus.interrupt_mask        = mask;
            bus.in_service_register   = isr;
            bus.special_mask_mode     = smm;
            bus.interrupt_request_pin = pins;
            tick();
            tick();
            w = model_winner(pins & ~mask, isr, model_ptr, smm);
            exp_oh = lvl_onehot(w);
            total_cnt++;
            if (bus.interrupt_to_cpu !== (w >= 0) || bus.interrupt_request_register !== pins)
                $display("FAIL rnd%0d_int got=%b/%h exp=%b/%h", it, bus.interrupt_to_cpu,
                         bus.interrupt_request_register, (w >= 0), pins);
            else pass_cnt++;
            inta_pulse();
            total_cnt++;
            if (bus.highest_priority_interrupt !== exp_oh || bus.acknowledge !== (w >= 0) ||
                bus.vector_level !== ((w >= 0) ? 3'(w) : 3'd7))
                $display("FAIL rnd%0d_ack1 got=%h/%b/%0d exp=%h/%b/%0d", it,
                         bus.highest_priority_interrupt, bus.acknowledge, bus.vector_level,
                         exp_oh, (w >= 0), (w >= 0) ? w : 7);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (bus.interrupt_request_register !== (lvl_mode ? pins : (pins & ~exp_oh)))
                $display("FAIL rnd%0d_irr got=%h exp=%h", it, bus.interrupt_request_register,
                         lvl_mode ? pins : (pins & ~exp_oh));
            else pass_cnt++;
            // Disturb inputs during WAIT2; the frozen winner must hold.
            bus.interrupt_mask      = 8'($urandom_range(0, 255));
            bus.in_service_register = 8'($urandom_range(0, 255));
            inta_pulse();
            total_cnt++;
            if (bus.end_of_acknowledge !== 1'b1 || bus.highest_priority_interrupt !== exp_oh)
                $display("FAIL rnd%0d_ack2 got=%b/%h exp=1/%h", it, bus.end_of_acknowledge,
                         bus.highest_priority_interrupt, exp_oh);
            else pass_cnt++;
            tick();
        end
        bus.level_or_edge_triggered_config = 1'b0;
        quiet();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_edge_basic();
        test_rotation();
        test_isr_blocking();
        test_spurious();
        test_level_mode();
        test_reset_mid_cycle();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
